// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises bitstream words LSB-first onto ccff_head and gates
// the chain shift with prog_clk_en. Define CCFF_READBACK_EN to add a ccff_tail verify pass.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
`ifdef CCFF_READBACK_EN
  localparam logic [2:0] S_VFETCH = 3'd3;
  localparam logic [2:0] S_VSHIFT = 3'd4;
`endif

  localparam int              IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [2:0]        state, state_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic              done_nxt;
  logic              fetching, shifting;
  logic              pass_end, word_end;

  // Both passes share the FETCH/SHIFT datapath; only the state codes differ.
  always_comb begin
    fetching = (state == S_FETCH);
    shifting = (state == S_SHIFT);
`ifdef CCFF_READBACK_EN
    fetching = fetching || (state == S_VFETCH);
    shifting = shifting || (state == S_VSHIFT);
`endif
  end

  assign pass_end    = (bit_cnt == LAST_BIT);
  assign word_end    = (bit_idx == LAST_IDX);
  assign word_ready  = fetching;
  assign prog_clk_en = shifting;
  assign ccff_head   = shifting & shreg[0];
  assign busy        = (state != S_IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    done_nxt    = 1'b0;

    if (fetching && word_valid) begin
      shreg_nxt   = word_in;
      bit_idx_nxt = '0;
    end

    if (shifting) begin
      shreg_nxt   = shreg >> 1;
      bit_cnt_nxt = pass_end ? '0 : bit_cnt + 1'b1;
      bit_idx_nxt = bit_idx + 1'b1;
    end

    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt   = S_FETCH;
            bit_cnt_nxt = '0;
          end
        end
        S_FETCH: begin
          if (word_valid) state_nxt = S_SHIFT;
        end
        S_SHIFT: begin
          // A partial last word is cut short here; its upper bits never leave shreg.
          if (pass_end) begin
`ifdef CCFF_READBACK_EN
            state_nxt = S_VFETCH;
`else
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
`endif
          end else if (word_end) begin
            state_nxt = S_FETCH;
          end
        end
`ifdef CCFF_READBACK_EN
        S_VFETCH: begin
          if (word_valid) state_nxt = S_VSHIFT;
        end
        S_VSHIFT: begin
          if (pass_end) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else if (word_end) begin
            state_nxt = S_VFETCH;
          end
        end
`endif
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      done    <= done_nxt;
    end
  end

  // NOTE: the word register is reset too, so ccff_head can never show X after reset.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) shreg <= '0;
    else               shreg <= shreg_nxt;
  end

`ifdef CCFF_READBACK_EN
  // After CHAIN_LEN shifts the tail presents the pass-1 bit now being re-driven on the head.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      error <= 1'b0;
    end else if ((state == S_IDLE) && start && !abort) begin
      error <= 1'b0;
    end else if ((state == S_VSHIFT) && (ccff_tail != shreg[0])) begin
      error <= 1'b1;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign error       = 1'b0;
`endif

endmodule
